// File: rtl/data_mem_responder_if.sv
// Request/response bus between the CPU load/store datapath and the data-memory responder.
// The master side issues requests and consumes responses; the slave side is the memory.
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_length;
   logic        req_signed;
   logic [31:0] req_address;
   logic [31:0] req_write_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_read_data;
   logic        rsp_error;

   modport master (
      output req_valid, req_write, req_length, req_signed, req_address, req_write_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_read_data, rsp_error
   );

   modport slave (
      input  req_valid, req_write, req_length, req_signed, req_address, req_write_data, rsp_ready,
      output req_ready, rsp_valid, rsp_read_data, rsp_error
   );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store per handshake, waits WAIT_CYCLES,
// performs a byte/half/word access on a word-organised array and returns formatted read data.
// Optional macro MEM_MISALIGN_ERR_EN: when defined, misaligned half/word accesses fault;
// when undefined, the offending low address bits are cleared and the access proceeds.
module data_mem_responder #(
   parameter int          DEPTH        = 1024,
   parameter int          WAIT_CYCLES  = 1,
   parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
   input  logic                       SYS_clk,
   input  logic                       SYS_reset,
   data_mem_responder_if.slave        bus,
   output logic                       busy
);

   localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          CW      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          write_q, write_d;
   logic [1:0]    length_q, length_d;
   logic          signed_q, signed_d;
   logic [31:0]   address_q, address_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rsp_data_q, rsp_data_d;
   logic          rsp_error_q, rsp_error_d;

   logic [31:0]   mem_q [DEPTH];

   logic [31:0]   eff_addr;
   logic          misaligned;
   logic [31:0]   word_idx;
   logic          in_range;
   logic [IW-1:0] mem_index;
   logic [31:0]   rd_word;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;
   logic [31:0]   load_data;
   logic [31:0]   st_word;
   logic          acc_error;
   logic          acc_store;
   logic [31:0]   acc_data;
   logic          mem_we;

   // Decode the captured request into an effective address, range/alignment verdict,
   // the formatted load value and the merged store word.
   always_comb begin
      eff_addr   = address_q;
      misaligned = 1'b0;
`ifdef MEM_MISALIGN_ERR_EN
      misaligned = ((length_q == 2'b10) && address_q[0]) ||
                   ((length_q == 2'b11) && (address_q[1:0] != 2'b00));
`else
      if (length_q == 2'b10) begin
         eff_addr[0] = 1'b0;
      end else if (length_q == 2'b11) begin
         eff_addr[1:0] = 2'b00;
      end
`endif
      word_idx  = (eff_addr - BASE_ADDRESS) >> 2;
      in_range  = (eff_addr >= BASE_ADDRESS) && (word_idx < DEPTH_W);
      mem_index = word_idx[IW-1:0];
      rd_word   = mem_q[mem_index];

      rd_byte = rd_word[7:0];
      st_word = rd_word;
      case (eff_addr[1:0])
         2'd0: rd_byte = rd_word[7:0];
         2'd1: rd_byte = rd_word[15:8];
         2'd2: rd_byte = rd_word[23:16];
         default: rd_byte = rd_word[31:24];
      endcase
      rd_half = eff_addr[1] ? rd_word[31:16] : rd_word[15:0];

      load_data = 32'h0;
      case (length_q)
         2'b01: begin
            load_data = signed_q ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            case (eff_addr[1:0])
               2'd0: st_word[7:0]   = wdata_q[7:0];
               2'd1: st_word[15:8]  = wdata_q[7:0];
               2'd2: st_word[23:16] = wdata_q[7:0];
               default: st_word[31:24] = wdata_q[7:0];
            endcase
         end
         2'b10: begin
            load_data = signed_q ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            if (eff_addr[1]) begin
               st_word[31:16] = wdata_q[15:0];
            end else begin
               st_word[15:0] = wdata_q[15:0];
            end
         end
         2'b11: begin
            load_data = rd_word;
            st_word   = wdata_q;
         end
         default: begin
            load_data = 32'h0;
         end
      endcase

      acc_error = !in_range || misaligned;
      acc_store = !acc_error && (length_q != 2'b00) && write_q;
      acc_data  = (!acc_error && (length_q != 2'b00) && !write_q) ? load_data : 32'h0;
   end

   // Next-state logic: IDLE captures a request, WAIT counts down, ACCESS registers the
   // response and commits stores, RESP holds until the consumer takes the response.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      write_d     = write_q;
      length_d    = length_q;
      signed_d    = signed_q;
      address_d   = address_q;
      wdata_d     = wdata_q;
      rsp_data_d  = rsp_data_q;
      rsp_error_d = rsp_error_q;
      mem_we      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               write_d   = bus.req_write;
               length_d  = bus.req_length;
               signed_d  = bus.req_signed;
               address_d = bus.req_address;
               wdata_d   = bus.req_write_data;
               if (WAIT_CYCLES > 0) begin
                  state_d = S_WAIT;
                  count_d = CW'(WAIT_CYCLES - 1);
               end else begin
                  state_d = S_ACCESS;
               end
            end
         end
         S_WAIT: begin
            if (count_q == '0) begin
               state_d = S_ACCESS;
            end else begin
               count_d = count_q - 1'b1;
            end
         end
         S_ACCESS: begin
            rsp_data_d  = acc_data;
            rsp_error_d = acc_error;
            mem_we      = acc_store;
            state_d     = S_RESP;
         end
         default: begin
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // Control and captured-request registers; reset drops any request in flight.
   always_ff @(posedge SYS_clk) begin
      if (SYS_reset) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         write_q     <= 1'b0;
         length_q    <= 2'b00;
         signed_q    <= 1'b0;
         address_q   <= 32'h0;
         wdata_q     <= 32'h0;
         rsp_data_q  <= 32'h0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         write_q     <= write_d;
         length_q    <= length_d;
         signed_q    <= signed_d;
         address_q   <= address_d;
         wdata_q     <= wdata_d;
         rsp_data_q  <= rsp_data_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   // Storage array; contents survive reset, but a reset edge suppresses a pending write.
   always_ff @(posedge SYS_clk) begin
      if (!SYS_reset && mem_we) begin
         mem_q[mem_index] <= st_word;
      end
   end

   assign bus.req_ready     = (state_q == S_IDLE);
   assign bus.rsp_valid     = (state_q == S_RESP);
   assign bus.rsp_read_data = rsp_data_q;
   assign bus.rsp_error     = rsp_error_q;
   assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a byte-level memory model predicts every
// response, a compare process checks each response cycle, and directed loads pin literals.
module tb_data_mem_responder;

   localparam int          DEPTH = 1024;
   localparam int          WAIT_CYCLES = 1;
   localparam logic [31:0] BASE = 32'h0000_0000;

   logic SYS_clk = 1'b0;
   logic SYS_reset = 1'b1;
   logic busy;

   data_mem_responder_if bus();

   data_mem_responder #(
      .DEPTH(DEPTH),
      .WAIT_CYCLES(WAIT_CYCLES),
      .BASE_ADDRESS(BASE)
   ) dut (
      .SYS_clk(SYS_clk),
      .SYS_reset(SYS_reset),
      .bus(bus),
      .busy(busy)
   );

   always #5 SYS_clk = ~SYS_clk;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          accept_edge;
   } exp_t;

   exp_t        exp_q[$];
   bit [7:0]    mdl [bit [31:0]];
   int          compared = 0;
   int          mismatched = 0;
   int          edge_cnt = 0;
   bit          seen_first = 1'b0;
   logic [31:0] last_data = 32'h0;
   logic        last_err = 1'b0;

   always @(posedge SYS_clk) edge_cnt <= edge_cnt + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
      end
   endtask

   task automatic reportTimeout(input string name);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: timed out waiting", name);
   endtask

   // Byte-addressed reference of what the memory must do for one request.
   function automatic void modelRequest(input bit wr, input bit [1:0] len, input bit sgn,
                                        input bit [31:0] addr, input bit [31:0] wd,
                                        output bit [31:0] data, output bit err);
      bit [31:0] a;
      bit [31:0] v;
      int n;
      data = 32'h0;
      err  = 1'b0;
      a    = addr;
      n    = (len == 2'b01) ? 1 : ((len == 2'b10) ? 2 : 4);
      if (len >= 2'b10 && (addr % n) != 0) begin
`ifdef MEM_MISALIGN_ERR_EN
         err = 1'b1;
         return;
`else
         a = addr - (addr % n);
`endif
      end
      if (a < BASE || ((a - BASE) / 4) >= DEPTH) begin
         err = 1'b1;
         return;
      end
      if (len == 2'b00) return;
      if (wr) begin
         for (int i = 0; i < n; i++) mdl[a + i] = 8'((wd >> (8 * i)) & 32'hFF);
         return;
      end
      v = 32'h0;
      for (int i = 0; i < n; i++) begin
         if (mdl.exists(a + i)) v = v | (32'(mdl[a + i]) << (8 * i));
      end
      if (sgn && n < 4 && ((v >> (8 * n - 1)) & 32'h1) == 32'h1) v = v | (32'hFFFF_FFFF << (8 * n));
      data = v;
   endfunction

   // Response checker: every cycle a response is presented it must match the model.
   always @(negedge SYS_clk) begin
      if (!SYS_reset) begin
         if (bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
               reportTimeout("unexpected rsp_valid with nothing outstanding");
            end else begin
               checkOutput("rsp_read_data", bus.rsp_read_data, exp_q[0].data);
               checkOutput("rsp_error", 32'(bus.rsp_error), 32'(exp_q[0].err));
               checkOutput("req_ready during RESP", 32'(bus.req_ready), 32'd0);
               checkOutput("busy during RESP", 32'(busy), 32'd1);
               if (!seen_first) begin
                  checkOutput("latency", 32'(edge_cnt - exp_q[0].accept_edge), 32'(WAIT_CYCLES + 1));
                  seen_first = 1'b1;
               end
               if (bus.rsp_ready) begin
                  last_data  = bus.rsp_read_data;
                  last_err   = bus.rsp_error;
                  seen_first = 1'b0;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   // Issue one request, predict its response, optionally stall the consumer, wait for completion.
   task automatic applyStimulus(input bit wr, input bit [1:0] len, input bit sgn,
                                input bit [31:0] addr, input bit [31:0] wd, input int hold);
      exp_t e;
      bit [31:0] d;
      bit er;
      int guard;
      guard = 0;
      while (!bus.req_ready && guard < 100) begin
         @(posedge SYS_clk); #1;
         guard++;
      end
      if (!bus.req_ready) reportTimeout("req_ready");
      if (hold > 0) bus.rsp_ready = 1'b0;
      bus.req_valid      = 1'b1;
      bus.req_write      = wr;
      bus.req_length     = len;
      bus.req_signed     = sgn;
      bus.req_address    = addr;
      bus.req_write_data = wd;
      @(posedge SYS_clk); #1;
      bus.req_valid = 1'b0;
      modelRequest(wr, len, sgn, addr, wd, d, er);
      e.data = d;
      e.err = er;
      e.accept_edge = edge_cnt;
      exp_q.push_back(e);
      checkOutput("busy after accept", 32'(busy), 32'd1);
      checkOutput("req_ready after accept", 32'(bus.req_ready), 32'd0);
      if (hold > 0) begin
         guard = 0;
         while (!bus.rsp_valid && guard < 100) begin
            @(posedge SYS_clk); #1;
            guard++;
         end
         if (!bus.rsp_valid) reportTimeout("rsp_valid");
         for (int i = 0; i < hold; i++) begin
            @(posedge SYS_clk); #1;
            checkOutput("rsp_valid held", 32'(bus.rsp_valid), 32'd1);
         end
         bus.rsp_ready = 1'b1;
      end
      guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
         @(posedge SYS_clk); #1;
         guard++;
      end
      if (exp_q.size() != 0) begin
         reportTimeout("response");
         exp_q.delete();
      end
      @(posedge SYS_clk); #1;
   endtask

   task automatic expectLoad(input string name, input bit [1:0] len, input bit sgn,
                             input bit [31:0] addr, input logic [31:0] data, input logic err);
      applyStimulus(1'b0, len, sgn, addr, 32'h0, 0);
      checkOutput({name, " data"}, last_data, data);
      checkOutput({name, " error"}, 32'(last_err), 32'(err));
   endtask

   task automatic checkResetValues(input string name);
      checkOutput({name, " req_ready"}, 32'(bus.req_ready), 32'd1);
      checkOutput({name, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      checkOutput({name, " busy"}, 32'(busy), 32'd0);
      checkOutput({name, " rsp_read_data"}, bus.rsp_read_data, 32'h0);
      checkOutput({name, " rsp_error"}, 32'(bus.rsp_error), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.req_valid      = 1'b0;
      bus.req_write      = 1'b0;
      bus.req_length     = 2'b00;
      bus.req_signed     = 1'b0;
      bus.req_address    = 32'h0;
      bus.req_write_data = 32'h0;
      bus.rsp_ready      = 1'b1;
      repeat (3) @(posedge SYS_clk);
      #1;
      SYS_reset = 1'b0;
      checkResetValues("initial reset");

      $display("[TB] word store / load");
      applyStimulus(1'b1, 2'b11, 1'b0, 32'h00, 32'h0102_0304, 0);
      applyStimulus(1'b1, 2'b11, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
      expectLoad("word 0x10", 2'b11, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);

      $display("[TB] byte extension");
      applyStimulus(1'b1, 2'b11, 1'b0, 32'h20, 32'h0000_0000, 0);
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h21, 32'h1234_5680, 0);
      expectLoad("byte signed 0x21", 2'b01, 1'b1, 32'h21, 32'hFFFF_FF80, 1'b0);
      expectLoad("byte unsigned 0x21", 2'b01, 1'b0, 32'h21, 32'h0000_0080, 1'b0);
      expectLoad("word 0x20", 2'b11, 1'b0, 32'h20, 32'h0000_8000, 1'b0);

      $display("[TB] half store / load");
      applyStimulus(1'b1, 2'b11, 1'b0, 32'h30, 32'h1122_3344, 0);
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h32, 32'hABCD_8001, 0);
      expectLoad("word 0x30", 2'b11, 1'b0, 32'h30, 32'h8001_3344, 1'b0);
      expectLoad("half signed 0x32", 2'b10, 1'b1, 32'h32, 32'hFFFF_8001, 1'b0);
      expectLoad("half unsigned 0x32", 2'b10, 1'b0, 32'h32, 32'h0000_8001, 1'b0);

      $display("[TB] no-op requests");
      expectLoad("noop load", 2'b00, 1'b0, 32'h10, 32'h0, 1'b0);
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h10, 32'h0, 0);
      expectLoad("word 0x10 after noop", 2'b11, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);

      $display("[TB] range boundary and back-pressure");
      applyStimulus(1'b1, 2'b11, 1'b0, 32'(4 * DEPTH - 4), 32'hA5A5_5A5A, 0);
      expectLoad("last word", 2'b11, 1'b0, 32'(4 * DEPTH - 4), 32'hA5A5_5A5A, 1'b0);
      applyStimulus(1'b0, 2'b11, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 5);
      checkOutput("out of range data", last_data, 32'h0);
      checkOutput("out of range error", 32'(last_err), 32'd1);
      applyStimulus(1'b1, 2'b11, 1'b0, BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 0);
      expectLoad("word 0x0 after bad store", 2'b11, 1'b0, 32'h00, 32'h0102_0304, 1'b0);

      $display("[TB] reset during WAIT");
      applyStimulus(1'b1, 2'b11, 1'b0, 32'h40, 32'hCAFE_F00D, 0);
      bus.req_valid      = 1'b1;
      bus.req_write      = 1'b1;
      bus.req_length     = 2'b11;
      bus.req_address    = 32'h40;
      bus.req_write_data = 32'h1234_5678;
      @(posedge SYS_clk); #1;
      bus.req_valid = 1'b0;
      checkOutput("busy in WAIT", 32'(busy), 32'd1);
      SYS_reset = 1'b1;
      @(posedge SYS_clk); #1;
      SYS_reset = 1'b0;
      checkResetValues("mid-request reset");
      @(posedge SYS_clk); #1;
      expectLoad("word 0x40 after reset", 2'b11, 1'b0, 32'h40, 32'hCAFE_F00D, 1'b0);

      $display("[TB] misalignment");
`ifdef MEM_MISALIGN_ERR_EN
      expectLoad("misaligned word 0x42", 2'b11, 1'b0, 32'h42, 32'h0, 1'b1);
      expectLoad("misaligned half 0x43", 2'b10, 1'b1, 32'h43, 32'h0, 1'b1);
`else
      expectLoad("misaligned word 0x42", 2'b11, 1'b0, 32'h42, 32'hCAFE_F00D, 1'b0);
      expectLoad("misaligned half 0x43", 2'b10, 1'b1, 32'h43, 32'hFFFF_CAFE, 1'b0);
`endif
      expectLoad("byte 0x43", 2'b01, 1'b0, 32'h43, 32'h0000_00CA, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
